// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types for shift_reg_ctrl: FSM state encoding and beat-counter sizing.
package shift_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_PAR   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit load/shift register: parallel load has priority over right shift with zero fill.
module shift_reg_core #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Parallel-in, LSB-first serial-out controller around shift_reg_core.
// Define SHIFT_REG_CTRL_PARITY_EN to append an even-parity beat after the data beats.
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] par_out
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_beat;
    logic             w_last;
    logic [WIDTH-1:0] w_q;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_beat   = (r_state == ST_SHIFT) && sout_ready;
    assign w_last   = (r_cnt == LAST);

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_load  (w_accept),
        .i_shift (w_beat),
        .i_din   (din),
        .o_q     (w_q)
    );

    // Counter holds at LAST on the final beat so it never needs a WIDTH-valued code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (sout_ready) begin
                        if (w_last) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
                            r_state <= ST_PAR;
`else
                            r_state <= ST_DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_PAR: begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
                    if (sout_ready) begin
                        r_state <= ST_DONE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^din;
        end
    end

    assign sout       = ((r_state == ST_SHIFT) && w_q[0]) ||
                        ((r_state == ST_PAR) && r_parity);
    assign sout_valid = (r_state == ST_SHIFT) || (r_state == ST_PAR);
`else
    assign sout       = (r_state == ST_SHIFT) && w_q[0];
    assign sout_valid = (r_state == ST_SHIFT);
`endif

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign par_out  = w_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl at WIDTH=4 (parity beat expected when SHIFT_REG_CTRL_PARITY_EN is defined).
module tb_shift_reg_ctrl;

`ifdef SHIFT_REG_CTRL_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] din;
    logic       in_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       busy;
    logic       done;
    logic [3:0] par_out;

    int errors = 0;
    int checks = 0;

    shift_reg_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .din        (din),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .busy       (busy),
        .done       (done),
        .par_out    (par_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts w, then runs until done (bounded); returns in the cycle after done.
    // Cycle 1 is the first cycle after the accept edge.
    task automatic send_word(input logic [3:0] w, input int stall_at, input int stall_len,
                             input logic nxt_v, input logic [3:0] nxt,
                             output logic [7:0] bits, output int nb, output int dcyc,
                             output int nd, output logic [1:0] st_sout, output logic [1:0] st_valid);
        bits = '0; nb = 0; dcyc = -1; nd = 0; st_sout = '0; st_valid = '0;
        in_valid = 1'b1; din = w; sout_ready = 1'b1;
        tick();
        in_valid = nxt_v;
        din      = nxt_v ? nxt : 4'h0;
        for (int c = 1; c <= 30; c++) begin
            sout_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (c == stall_at)     begin st_sout[0] = sout; st_valid[0] = sout_valid; end
            if (c == stall_at + 1) begin st_sout[1] = sout; st_valid[1] = sout_valid; end
            if (sout_valid && sout_ready && nb < 8) begin
                bits[nb] = sout;
                nb++;
            end
            if (done) begin
                nd++;
                if (dcyc < 0) dcyc = c;
            end
            tick();
            if (dcyc >= 0) break;
        end
        sout_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; din = 4'h0; sout_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({in_ready, sout, sout_valid, busy, done, par_out} !== 9'b1_0_0_0_0_0000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b sout=%b sv=%b busy=%b done=%b par=%b, want 1 0 0 0 0 0000",
                     in_ready, sout, sout_valid, busy, done, par_out);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        send_word(4'b1011, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b1011) begin
            errors++;
            $display("FAIL basic_stream: got %0d beats bits=%b, want %0d beats bits[3:0]=1011", nb, bits, NB);
        end
        checks++;
        if (dcyc != NB + 1 || nd != 1) begin
            errors++;
            $display("FAIL basic_done_cycle: got cycle %0d count %0d, want cycle %0d count 1", dcyc, nd, NB + 1);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || par_out !== 4'b0000) begin
            errors++;
            $display("FAIL basic_return_idle: got rdy=%b busy=%b done=%b par=%b, want 1 0 0 0000",
                     in_ready, busy, done, par_out);
        end
    endtask

    task automatic test_par_out();
        logic [3:0] expq;
        in_valid = 1'b1; din = 4'b1101; sout_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        expq = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (par_out !== expq || sout !== expq[0] || sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL par_out_beat%0d: got par=%b sout=%b sv=%b, want par=%b sout=%b sv=1",
                         i, par_out, sout, sout_valid, expq, expq[0]);
            end
            expq = {1'b0, expq[3:1]};
            tick();
        end
        for (int i = 0; i < 10 && !in_ready; i++) tick();
        checks++;
        if (par_out !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL par_out_final: got par=%b rdy=%b, want 0000 1", par_out, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        send_word(4'b1011, 3, 2, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (ss !== 2'b00 || sv !== 2'b11) begin
            errors++;
            $display("FAIL bp_stall_hold: got sout=%b sv=%b over stall, want 00 11", ss, sv);
        end
        checks++;
        if (nb != NB || bits[3:0] !== 4'b1011) begin
            errors++;
            $display("FAIL bp_stream: got %0d beats bits=%b, want %0d beats bits[3:0]=1011", nb, bits, NB);
        end
        checks++;
        if (dcyc != NB + 3 || nd != 1) begin
            errors++;
            $display("FAIL bp_done_cycle: got cycle %0d count %0d, want cycle %0d count 1", dcyc, nd, NB + 3);
        end
    endtask

    task automatic test_parity();
`ifdef SHIFT_REG_CTRL_PARITY_EN
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        send_word(4'b1011, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != 5 || bits[4] !== 1'b1) begin
            errors++;
            $display("FAIL parity_1011: got %0d beats parity=%b, want 5 beats parity=1", nb, bits[4]);
        end
        send_word(4'b0110, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != 5 || bits[4:0] !== 5'b00110) begin
            errors++;
            $display("FAIL parity_0110: got %0d beats bits=%b, want 5 beats bits=00110", nb, bits[4:0]);
        end
`endif
    endtask

    task automatic test_ignored_input();
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        send_word(4'b1011, 0, 0, 1'b1, 4'b1111, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b1011 || dcyc != NB + 1) begin
            errors++;
            $display("FAIL ignored_stream: got %0d beats bits=%b done@%0d, want %0d bits[3:0]=1011 done@%0d",
                     nb, bits, dcyc, NB, NB + 1);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_idle: got rdy=%b, want 1", in_ready);
        end
        send_word(4'b1111, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b1111) begin
            errors++;
            $display("FAIL ignored_next_word: got %0d beats bits=%b, want %0d bits[3:0]=1111", nb, bits, NB);
        end
    endtask

    task automatic test_midword_reset();
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        in_valid = 1'b1; din = 4'b1011; sout_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || par_out !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: got sv=%b busy=%b done=%b par=%b, want 0 0 0 0000",
                     sout_valid, busy, done, par_out);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got rdy=%b done=%b, want 1 0", in_ready, done);
        end
        send_word(4'b0001, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b0001 || dcyc != NB + 1 || nd != 1) begin
            errors++;
            $display("FAIL midreset_next_word: got %0d beats bits=%b done@%0d x%0d, want %0d 0001 done@%0d x1",
                     nb, bits, dcyc, nd, NB, NB + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits; int nb, dcyc, nd; logic [1:0] ss, sv;
        send_word(4'b0101, 0, 0, 1'b1, 4'b1010, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b0101 || nd != 1 || dcyc != NB + 1) begin
            errors++;
            $display("FAIL b2b_word0: got %0d beats bits=%b done x%0d @%0d, want %0d 0101 x1 @%0d",
                     nb, bits, nd, dcyc, NB, NB + 1);
        end
        send_word(4'b1010, 0, 0, 1'b0, 4'h0, bits, nb, dcyc, nd, ss, sv);
        checks++;
        if (nb != NB || bits[3:0] !== 4'b1010 || nd != 1 || dcyc != NB + 1) begin
            errors++;
            $display("FAIL b2b_word1: got %0d beats bits=%b done x%0d @%0d, want %0d 1010 x1 @%0d",
                     nb, bits, nd, dcyc, NB, NB + 1);
        end
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail: got done=%b rdy=%b, want 0 1", done, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_par_out();
        test_backpressure();
        test_parity();
        test_ignored_input();
        test_midword_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

- Sequencing controller and datapath for a WIDTH-bit load/shift register: accepts a parallel word over a valid/ready handshake and loads it into the register.
- Shifts the word out serially, LSB first, under downstream back-pressure, then pulses `done`.
- Sits between a parallel producer and a bit-serial consumer. It owns the register's load-enable/shift sequencing, which the DFF-based register datapaths leave to the surrounding logic.

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits. Legal range is WIDTH ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  producer has a word on `din`.
- `din`  in  WIDTH  parallel word.
- `in_ready`  out  1  controller can accept a word.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` is valid.
- `sout_ready`  in  1  consumer takes `sout` this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last serial beat.
- `par_out`  out  WIDTH  current register contents, for observation.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `sout_valid`=1, `sout`=reg[0].
  - PAR: only with the macro enabled; `sout_valid`=1, `sout`=stored parity.
  - DONE: `done`=1, `in_ready`=0.
- IDLE → SHIFT on `in_valid && in_ready`. At that edge: reg ← `din`, beat counter ← 0, parity ← ^`din`.
- SHIFT, beat accepted (`sout_valid && sout_ready`):
  - reg ← {1'b0, reg[WIDTH-1:1]};
  - counter ← counter+1.
  - On the beat where counter == WIDTH-1: go to PAR if enabled, otherwise to DONE.
- SHIFT, no acceptance (stall): reg, counter, `sout` and `sout_valid` hold unchanged. A stall has no length limit.
- PAR → DONE when the parity beat is accepted.
- DONE → IDLE unconditionally after one cycle.
- `in_valid` outside IDLE is ignored. `din` is sampled only on the accept edge.
- Counter width is $clog2(WIDTH). The counter never wraps, because the state exits at WIDTH-1.
- `par_out` shows the register as it shifts. After the last shift it is all zeros.
- Reset values: state=IDLE, reg=0, counter=0, parity=0. Outputs: `in_ready`=1, `sout`=0, `sout_valid`=0, `busy`=0, `done`=0, `par_out`=0.
- Reset asserted mid-word: the word is abandoned and `sout_valid` drops asynchronously. After release the block is in IDLE, with no `done` pulse for the abandoned word.

## Timing
- Accept edge at cycle k, with `sout_ready` held high:
  - beats in cycles k+1 .. k+WIDTH (plus k+WIDTH+1 for PAR);
  - `done` in the cycle after the last beat;
  - `in_ready` high again the following cycle.
- WIDTH=4 without parity: accept at k, beats at k+1..k+4, `done` at k+5, `in_ready` at k+6.
- Outputs are registered or state-decoded only, with no combinational path from `sout_ready` or `in_valid` to any output.
- Minimum spacing between accepted words is WIDTH+2 cycles without parity, WIDTH+3 with parity.

## Configuration
- Macro `SHIFT_REG_CTRL_PARITY_EN`.
- Defined: the PAR state and parity register are compiled in, and one extra beat carrying even parity (^word) follows the data beats.
- Undefined: SHIFT goes directly to DONE, and no parity logic exists.

## Structure
- Package `shift_reg_ctrl_pkg` holds:
  - the state typedef (IDLE, SHIFT, PAR, DONE) with fixed 2-bit encodings 00/01/10/11;
  - the beat-counter width function.
- Sub-module `shift_reg_core`: WIDTH-bit register with async reset, `load` (parallel write) and `shift` (right shift, zero fill), with `load` having priority.
- `shift_reg_ctrl` contains the FSM, counter and parity, and drives `load`/`shift` on `shift_reg_core`.

## Test plan
- Basic serialisation: WIDTH=4, `din`=4'b1011, `sout_ready`=1 → `sout` 1,1,0,1 in cycles k+1..k+4; `done` at k+5; `in_ready` at k+6.
- Back-pressure: same word, `sout_ready`=0 for 2 cycles while beat 2 (value 0) is presented → `sout`=0 and `sout_valid`=1 held; 4 beats total; `done` 2 cycles later than in the basic case.
- Parity build: with the macro defined, `din`=4'b1011 → 5th beat `sout`=1; `din`=4'b0110 → 5th beat `sout`=0.
- Ignored input: `in_valid`=1 with `din`=4'b1111 during SHIFT → the serial stream of the current word is unchanged, and a new accept happens only at the next IDLE.
- Mid-word reset: assert `reset` after beat 1 → `sout_valid`=0 and `busy`=0 immediately; after release `in_ready`=1 and the next word 4'b0001 serialises correctly.
- Back-to-back words: `in_valid` held high with 4'b0101 then 4'b1010 → bit streams 1,0,1,0 and 0,1,0,1 with exactly one `done` per word.
